data_to_decrypt: RTL and testbench
==================================

DATA_TO_DECRYPT -- requirements
Module: data_to_decrypt

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the data path.
REQ-002 The block SHALL have parameter SWAP_BYTES, default 0; 0 passes the word unchanged and 1 reverses byte order (DATA_WIDTH multiple of 8).
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port n_rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port read_ready_i, input, 1 bit: rc4_data_i holds a valid word this cycle.
REQ-006 The block SHALL have port rc4_data_i, input, DATA_WIDTH bits: word read from RC4 data memory.
REQ-007 The block SHALL have port dataToDecrypt_o, output, DATA_WIDTH bits: most recently captured word, held for the decryption stage.
REQ-008 The block SHALL have port data_valid_o, output, 1 bit: single-cycle pulse marking a newly captured word.
REQ-009 The block SHALL have port word_count_o, output, 16 bits: number of words captured since reset, saturating.

Function
REQ-010 On a rising edge of clk_i with read_ready_i=1, dataToDecrypt_o SHALL load rc4_data_i, byte-reversed if SWAP_BYTES=1, so the new value appears one cycle after the sampling edge.
REQ-011 On a rising edge with read_ready_i=0, dataToDecrypt_o SHALL hold its previous value; rc4_data_i is ignored.
REQ-012 data_valid_o SHALL be registered: 1 in the cycle after any edge that sampled read_ready_i=1, else 0.
REQ-013 With read_ready_i held at 1 over consecutive edges, data_valid_o SHALL stay at 1 and dataToDecrypt_o SHALL update every cycle (no bubbles, no back-pressure).
REQ-014 word_count_o SHALL increment by 1 on each edge sampling read_ready_i=1.
REQ-015 word_count_o SHALL saturate at 16'hFFFF and never wrap.
REQ-016 An X or Z on read_ready_i SHALL NOT be required to be handled; the bench drives known values only.
REQ-017 All outputs SHALL be driven directly from flip-flops, with no combinational path from inputs to outputs.
REQ-018 The block SHALL be fully synthesizable, with no latches and no internal state beyond the output registers, the valid flag and the counter.

Reset
REQ-019 While n_rst_i=0, dataToDecrypt_o SHALL be 0, data_valid_o SHALL be 0 and word_count_o SHALL be 0, asynchronously and regardless of clk_i.
REQ-020 Assertion of reset mid-stream SHALL discard any capture in progress.
REQ-021 After n_rst_i deasserts, the first rising edge with read_ready_i=1 SHALL capture normally.

Verification
REQ-022 Reset released; read_ready_i=0, rc4_data_i=44 for one edge -> dataToDecrypt_o=0, data_valid_o=0, word_count_o=0.
REQ-023 read_ready_i=1, rc4_data_i=213231 (0x000340EF), then read_ready_i=1, rc4_data_i=6969, then read_ready_i=0, rc4_data_i=69 -> dataToDecrypt_o reads 213231, then 6969, then holds 6969; data_valid_o reads 1,1,0; word_count_o reads 1,2,2.
REQ-024 SWAP_BYTES=1, read_ready_i=1, rc4_data_i=0x11223344 -> next cycle dataToDecrypt_o=0x44332211.
REQ-025 n_rst_i pulsed low between clock edges while dataToDecrypt_o=6969 -> all outputs 0 immediately; the following capture of 0xDEADBEEF gives dataToDecrypt_o=0xDEADBEEF and word_count_o=1.
REQ-026 read_ready_i held at 1 for 65,540 cycles -> word_count_o reaches 0xFFFF and stays there; dataToDecrypt_o tracks input with one-cycle latency throughout.

Source files
------------

// File: rtl/data_to_decrypt.sv
// data_to_decrypt: captures words read from RC4 data memory and holds the most
// recent one for the decryption stage. Each capture raises a registered
// one-cycle valid flag and advances a saturating 16-bit word counter.
// An optional byte reversal adapts the memory's byte order to the decryptor.

module data_to_decrypt #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          SWAP_BYTES = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  n_rst_i,
    input  logic                  read_ready_i,
    input  logic [DATA_WIDTH-1:0] rc4_data_i,
    output logic [DATA_WIDTH-1:0] dataToDecrypt_o,
    output logic                  data_valid_o,
    output logic [15:0]           word_count_o
);

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [DATA_WIDTH-1:0] captureWord;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [15:0]           count_q, count_d;

    generate
        if (SWAP_BYTES) begin : gSwap
            // Reverse byte order: byte 0 of the result is the top byte of the input.
            always_comb begin
                captureWord = '0;
                for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                    captureWord[8*b +: 8] = rc4_data_i[DATA_WIDTH - 8 - 8*b +: 8];
                end
            end
        end else begin : gPass
            assign captureWord = rc4_data_i;
        end
    endgenerate

    // Next-state logic: load on read_ready_i, hold otherwise; the counter stops at all-ones.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        count_d = count_q;
        if (read_ready_i) begin
            data_d  = captureWord;
            valid_d = 1'b1;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // State registers; reset clears everything, discarding any pending capture.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign dataToDecrypt_o = data_q;
    assign data_valid_o    = valid_q;
    assign word_count_o    = count_q;

endmodule

// File: tb/tb_data_to_decrypt.sv
// Testbench for data_to_decrypt. Two instances share the stimulus: one passes
// words through unchanged, the other byte-reverses them. Expected outputs are
// produced by a bench-side model when stimulus is driven, queued, and compared
// after the following rising edge.

module tb_data_to_decrypt;

    typedef struct {
        logic [31:0] data;
        logic [31:0] swapData;
        logic        valid;
        logic [15:0] count;
    } expT;

    logic        clk_i = 1'b0;
    logic        n_rst_i = 1'b0;
    logic        read_ready_i = 1'b0;
    logic [31:0] rc4_data_i = '0;

    logic [31:0] dataOut, swapDataOut;
    logic        validOut, swapValidOut;
    logic [15:0] countOut, swapCountOut;

    int checkCount = 0;
    int failCount  = 0;

    expT sb[$];

    logic [31:0] modelData = '0;
    logic [31:0] modelSwapData = '0;
    logic [15:0] modelCount = '0;

    data_to_decrypt #(.DATA_WIDTH(32), .SWAP_BYTES(1'b0)) dut (
        .clk_i           (clk_i),
        .n_rst_i         (n_rst_i),
        .read_ready_i    (read_ready_i),
        .rc4_data_i      (rc4_data_i),
        .dataToDecrypt_o (dataOut),
        .data_valid_o    (validOut),
        .word_count_o    (countOut)
    );

    data_to_decrypt #(.DATA_WIDTH(32), .SWAP_BYTES(1'b1)) dutSwap (
        .clk_i           (clk_i),
        .n_rst_i         (n_rst_i),
        .read_ready_i    (read_ready_i),
        .rc4_data_i      (rc4_data_i),
        .dataToDecrypt_o (swapDataOut),
        .data_valid_o    (swapValidOut),
        .word_count_o    (swapCountOut)
    );

    always #5 clk_i = ~clk_i;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] byteSwap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data"},      dataOut, 32'h0);
        checkOutput({tag, "_valid"},     {31'h0, validOut}, 32'h0);
        checkOutput({tag, "_count"},     {16'h0, countOut}, 32'h0);
        checkOutput({tag, "_swapData"},  swapDataOut, 32'h0);
        checkOutput({tag, "_swapValid"}, {31'h0, swapValidOut}, 32'h0);
        checkOutput({tag, "_swapCount"}, {16'h0, swapCountOut}, 32'h0);
    endtask

    // Drive one cycle of stimulus, queue the model's expectation, then compare after the edge.
    task automatic applyStimulus(input logic ready, input logic [31:0] word, input bit checkSwap);
        expT e;
        expT got;
        read_ready_i = ready;
        rc4_data_i   = word;
        if (ready) begin
            modelData     = word;
            modelSwapData = byteSwap32(word);
            if (modelCount != 16'hFFFF) modelCount = modelCount + 16'd1;
        end
        e.data     = modelData;
        e.swapData = modelSwapData;
        e.valid    = ready;
        e.count    = modelCount;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        got = sb.pop_front();
        checkOutput("data",  dataOut, got.data);
        checkOutput("valid", {31'h0, validOut}, {31'h0, got.valid});
        checkOutput("count", {16'h0, countOut}, {16'h0, got.count});
        if (checkSwap) begin
            checkOutput("swapData",  swapDataOut, got.swapData);
            checkOutput("swapValid", {31'h0, swapValidOut}, {31'h0, got.valid});
            checkOutput("swapCount", {16'h0, swapCountOut}, {16'h0, got.count});
        end
    endtask

    initial begin
        // Reset held from time zero: outputs must be clear before any clock edge.
        #1;
        checkAllZero("resetInit");
        @(posedge clk_i);
        #1;
        checkAllZero("resetHeld");
        #4;
        n_rst_i = 1'b1;

        // Idle cycle after reset: input ignored.
        applyStimulus(1'b0, 32'd44, 1'b1);

        // Two back-to-back captures, then a hold.
        applyStimulus(1'b1, 32'd213231, 1'b1);
        applyStimulus(1'b1, 32'd6969, 1'b1);
        applyStimulus(1'b0, 32'd69, 1'b1);

        // Byte reversal on the swapping instance.
        applyStimulus(1'b1, 32'h11223344, 1'b1);
        checkOutput("swapExplicit", swapDataOut, 32'h44332211);

        // Bring the held word back to 6969, then pulse reset between edges.
        applyStimulus(1'b0, 32'hCAFEF00D, 1'b1);
        applyStimulus(1'b1, 32'd6969, 1'b1);
        read_ready_i = 1'b1;
        rc4_data_i   = 32'h12345678;
        #2;
        n_rst_i = 1'b0;
        #1;
        checkAllZero("asyncReset");
        #1;
        n_rst_i = 1'b1;
        modelData     = '0;
        modelSwapData = '0;
        modelCount    = '0;

        // First capture after reset.
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
        checkOutput("postResetCount", {16'h0, countOut}, 32'd1);

        // Long streaming run: counter must saturate and data track every cycle.
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0);
        end
        checkOutput("saturated", {16'h0, countOut}, 32'h0000FFFF);

        // Idle cycles after saturation: everything holds.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, $urandom, 1'b1);
        end
        applyStimulus(1'b1, 32'hA5A5_0F0F, 1'b1);
        checkOutput("stillSaturated", {16'h0, countOut}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
